// File: rtl/enqueue_agent_v0_2.sv
// Enqueue agent: per-packet destination decode, drop/full checks and buffer/PIFO strobe steering.
// Optional statistics counters are built only when ENQ_STATS_EN is defined.
module enqueue_agent_v0_2 #(
  parameter int C_S_AXIS_TUSER_WIDTH = 128,
  parameter int NF_PORT_NUM          = 4,
  parameter int QUEUE_NUM            = 5,
  parameter int DST_POS              = 24,
  parameter int DROP_POS             = 32,
  parameter int MCAST_MODE           = 0,
  parameter int CNT_WIDTH            = 32
) (
  input  logic                            axis_aclk,
  input  logic                            axis_resetn,
  input  logic                            s_axis_tvalid,
  output logic                            s_axis_tready,
  input  logic [C_S_AXIS_TUSER_WIDTH-1:0] s_axis_tuser,
  input  logic                            s_axis_tlast,
  input  logic                            s_axis_tpifo_valid,
  input  logic [QUEUE_NUM-1:0]            s_axis_buffer_almost_full,
  input  logic [QUEUE_NUM-1:0]            s_axis_pifo_full,
  output logic [QUEUE_NUM-1:0]            m_axis_ctl_pifo_in_en,
  output logic [QUEUE_NUM-1:0]            m_axis_ctl_buffer_wr_en,
  output logic [CNT_WIDTH-1:0]            stat_enq_pkts,
  output logic [CNT_WIDTH-1:0]            stat_drop_pkts
);

  typedef enum logic [1:0] {IDLE, ENQ, DROP} state_t;

  state_t               state_q, state_d;
  logic [QUEUE_NUM-1:0] mask_q, mask_d;
  logic                 sop_q, sop_d;
  logic [QUEUE_NUM-1:0] dst, ok;
  logic                 drop;
  logic                 unused_tuser;

  assign unused_tuser = ^s_axis_tuser;

  // Even bits of dst_port are NF ports, odd bits all map to the CPU/DMA queue.
  always_comb begin
    dst = '0;
    for (int i = 0; i < NF_PORT_NUM; i++) begin
      dst[i]           = s_axis_tuser[DST_POS + 2*i];
      dst[NF_PORT_NUM] = dst[NF_PORT_NUM] | s_axis_tuser[DST_POS + 2*i + 1];
    end
  end

  assign ok = dst & ~s_axis_buffer_almost_full & ~s_axis_pifo_full;

  always_comb begin
    drop = s_axis_tuser[DROP_POS] | ~s_axis_tpifo_valid | (dst == '0);
    if (MCAST_MODE == 0) drop = drop | (ok == '0);
    else                 drop = drop | (ok != dst);
  end

  always_ff @(posedge axis_aclk or negedge axis_resetn) begin
    if (!axis_resetn) begin
      state_q <= IDLE;
      mask_q  <= '0;
      sop_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      mask_q  <= mask_d;
      sop_q   <= sop_d;
    end
  end

  always_comb begin
    state_d = state_q;
    mask_d  = mask_q;
    sop_d   = sop_q;
    case (state_q)
      IDLE: begin
        if (s_axis_tvalid) begin
          if (drop) begin
            state_d = DROP;
          end else begin
            state_d = ENQ;
            mask_d  = ok;
            sop_d   = 1'b1;
          end
        end
      end
      ENQ: begin
        if (s_axis_tvalid) begin
          sop_d = 1'b0;
          if (s_axis_tlast) state_d = IDLE;
        end
      end
      DROP: begin
        if (s_axis_tvalid && s_axis_tlast) state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  always_comb begin
    s_axis_tready           = 1'b0;
    m_axis_ctl_buffer_wr_en = '0;
    m_axis_ctl_pifo_in_en   = '0;
    case (state_q)
      ENQ: begin
        s_axis_tready = 1'b1;
        if (s_axis_tvalid) begin
          m_axis_ctl_buffer_wr_en = mask_q;
          if (sop_q) m_axis_ctl_pifo_in_en = mask_q;
        end
      end
      DROP:    s_axis_tready = 1'b1;
      default: s_axis_tready = 1'b0;
    endcase
  end

`ifdef ENQ_STATS_EN
  logic                 enq_done, drop_done;
  logic [CNT_WIDTH-1:0] enq_cnt_q, enq_cnt_d, drop_cnt_q, drop_cnt_d;
  localparam logic [CNT_WIDTH-1:0] CNT_ONE = {{(CNT_WIDTH-1){1'b0}}, 1'b1};

  assign enq_done  = (state_q == ENQ)  && s_axis_tvalid && s_axis_tlast;
  assign drop_done = (state_q == DROP) && s_axis_tvalid && s_axis_tlast;

  // Saturating: hold at all-ones rather than wrap.
  always_comb begin
    enq_cnt_d  = enq_cnt_q;
    drop_cnt_d = drop_cnt_q;
    if (enq_done  && !(&enq_cnt_q))  enq_cnt_d  = enq_cnt_q + CNT_ONE;
    if (drop_done && !(&drop_cnt_q)) drop_cnt_d = drop_cnt_q + CNT_ONE;
  end

  always_ff @(posedge axis_aclk or negedge axis_resetn) begin
    if (!axis_resetn) begin
      enq_cnt_q  <= '0;
      drop_cnt_q <= '0;
    end else begin
      enq_cnt_q  <= enq_cnt_d;
      drop_cnt_q <= drop_cnt_d;
    end
  end

  assign stat_enq_pkts  = enq_cnt_q;
  assign stat_drop_pkts = drop_cnt_q;
`else
  assign stat_enq_pkts  = '0;
  assign stat_drop_pkts = '0;
`endif

endmodule
